// File: rtl/xgemac_pkt_rx_reader_pkg.sv
// Shared types and constants for the xge_mac packet RX reader.
package xgemac_pkt_rx_reader_pkg;

    localparam int XGE_WORD_BYTES = 8;
    localparam int XGE_DATA_W     = 64;

    // One MAC receive word as held in the elastic buffer.
    typedef struct packed {
        logic [XGE_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
        logic [2:0]            mod;
        logic                  err;
    } rx_word_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rx_rd_state_e;

endpackage

// File: rtl/xgemac_pkt_rx_reader_fifo.sv
// Small first-word-fall-through FIFO of rx_word_t entries with occupancy count.
module xgemac_pkt_rx_reader_fifo
    import xgemac_pkt_rx_reader_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  rx_word_t      wr_word,
    input  logic          rd_en,
    output rx_word_t      rd_word,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    rx_word_t      mem_q [DEPTH];
    rx_word_t      mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ok_s, rd_ok_s;

    // Qualify push/pop and compute next storage, pointers and occupancy.
    always_comb begin
        rd_ok_s  = rd_en && (count_q != '0);
        wr_ok_s  = wr_en && ((count_q != CW'(DEPTH)) || rd_ok_s);
        mem_d    = mem_q;
        if (wr_ok_s) begin
            mem_d[wr_ptr_q] = wr_word;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset discards all contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_word = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/xgemac_pkt_rx_reader.sv
// Reader end of the xge_mac RX port: drains frames into a valid/ready stream,
// measures frame length and keeps saturating frame/byte statistics.
module xgemac_pkt_rx_reader
    import xgemac_pkt_rx_reader_pkg::*;
#(
    parameter int DATA_W          = 64,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int LEN_W           = 16,
    parameter int CNT_W           = 32
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25_n,
    input  logic              enable,
    input  logic              pkt_rx_avail,
    output logic              pkt_rx_ren,
    input  logic              pkt_rx_val,
    input  logic              pkt_rx_sop,
    input  logic              pkt_rx_eop,
    input  logic [2:0]        pkt_rx_mod,
    input  logic              pkt_rx_err,
    input  logic [DATA_W-1:0] pkt_rx_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_err,
    output logic [2:0]        out_mod,
    output logic [LEN_W-1:0]  frame_len,
    output logic              frame_len_vld,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_frames_ok,
    output logic [CNT_W-1:0]  stat_frames_err,
    output logic [CNT_W-1:0]  stat_bytes
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int XW = LEN_W + 4;   // headroom for 8*words before saturation

    rx_rd_state_e     state_q, state_d;
    logic             ren_q, ren_d;
    logic             in_frame_q, in_frame_d;
    logic             frame_len_vld_q, frame_len_vld_d;
    logic [LEN_W-1:0] wcnt_q, wcnt_d, wcnt_next_s;
    logic [LEN_W-1:0] frame_len_q, frame_len_d, len_sat_s;
    logic [XW-1:0]    bytes_ext_s;
    logic [CNT_W-1:0] ok_q, ok_d, err_q, err_d, bytes_q, bytes_d;
    logic [CNT_W:0]   ok_sum_s, err_sum_s, bytes_sum_s;
    logic [1:0]       err_inc_s;
    logic             wr_en_s, done_s, abort_s, oversize_s, frame_err_s;
    logic             room_s, pop_s;
    rx_word_t         wr_word_s, head_s;
    logic [CW-1:0]    fifo_count_s;

    // Words already requested (ren_q) still need a slot, so count them against capacity.
    assign room_s = ({1'b0, fifo_count_s} + {{CW{1'b0}}, ren_q}) < (CW+1)'(FIFO_DEPTH);

    // Reader FSM next state and MAC read enable.
    always_comb begin
        state_d = state_q;
        ren_d   = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (enable && pkt_rx_avail) begin
                    state_d = RD_READ;
                end else begin
                    state_d = RD_IDLE;
                end
            end
            RD_READ: begin
                if (pkt_rx_val && pkt_rx_eop) begin
                    state_d = RD_IDLE;
                    ren_d   = 1'b0;
                end else begin
                    state_d = RD_READ;
                    ren_d   = room_s;
                end
            end
            default: begin
                state_d = RD_IDLE;
                ren_d   = 1'b0;
            end
        endcase
    end

    assign pkt_rx_ren = ren_d;

    // Word capture, length measurement and oversize/error tagging.
    always_comb begin
        wr_en_s = pkt_rx_val && (state_q == RD_READ);
        if (pkt_rx_sop) begin
            wcnt_next_s = LEN_W'(1);
        end else if (wcnt_q == '1) begin
            wcnt_next_s = wcnt_q;
        end else begin
            wcnt_next_s = wcnt_q + LEN_W'(1);
        end
        if (pkt_rx_mod == 3'd0) begin
            bytes_ext_s = XW'(wcnt_next_s) * XW'(XGE_WORD_BYTES);
        end else begin
            bytes_ext_s = (XW'(wcnt_next_s) - XW'(1)) * XW'(XGE_WORD_BYTES) + XW'(pkt_rx_mod);
        end
        if (bytes_ext_s[XW-1:LEN_W] != '0) begin
            len_sat_s = '1;
        end else begin
            len_sat_s = bytes_ext_s[LEN_W-1:0];
        end
        oversize_s  = bytes_ext_s > XW'(MAX_FRAME_BYTES);
        frame_err_s = pkt_rx_err || oversize_s;
        done_s      = wr_en_s && pkt_rx_eop;
        // A sop arriving inside a frame abandons the partial frame.
        abort_s     = wr_en_s && pkt_rx_sop && in_frame_q;

        wr_word_s.data = pkt_rx_data;
        wr_word_s.sop  = pkt_rx_sop;
        wr_word_s.eop  = pkt_rx_eop;
        wr_word_s.mod  = pkt_rx_mod;
        wr_word_s.err  = pkt_rx_eop && frame_err_s;

        if (wr_en_s) begin
            wcnt_d     = wcnt_next_s;
            in_frame_d = !pkt_rx_eop;
        end else begin
            wcnt_d     = wcnt_q;
            in_frame_d = in_frame_q;
        end
        if (done_s) begin
            frame_len_d = len_sat_s;
        end else begin
            frame_len_d = frame_len_q;
        end
        frame_len_vld_d = done_s;
    end

    // Saturating statistics; a clear in the same cycle discards the update.
    always_comb begin
        err_inc_s   = {1'b0, done_s && frame_err_s} + {1'b0, abort_s};
        ok_sum_s    = {1'b0, ok_q} + (CNT_W+1)'(done_s && !frame_err_s);
        err_sum_s   = {1'b0, err_q} + (CNT_W+1)'(err_inc_s);
        bytes_sum_s = {1'b0, bytes_q} + (done_s ? (CNT_W+1)'(len_sat_s) : (CNT_W+1)'(0));
        if (stat_clr) begin
            ok_d    = '0;
            err_d   = '0;
            bytes_d = '0;
        end else begin
            ok_d    = ok_sum_s[CNT_W]    ? '1 : ok_sum_s[CNT_W-1:0];
            err_d   = err_sum_s[CNT_W]   ? '1 : err_sum_s[CNT_W-1:0];
            bytes_d = bytes_sum_s[CNT_W] ? '1 : bytes_sum_s[CNT_W-1:0];
        end
    end

    // Control, length and statistics registers.
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q         <= RD_IDLE;
            ren_q           <= 1'b0;
            in_frame_q      <= 1'b0;
            wcnt_q          <= '0;
            frame_len_q     <= '0;
            frame_len_vld_q <= 1'b0;
            ok_q            <= '0;
            err_q           <= '0;
            bytes_q         <= '0;
        end else begin
            state_q         <= state_d;
            ren_q           <= ren_d;
            in_frame_q      <= in_frame_d;
            wcnt_q          <= wcnt_d;
            frame_len_q     <= frame_len_d;
            frame_len_vld_q <= frame_len_vld_d;
            ok_q            <= ok_d;
            err_q           <= err_d;
            bytes_q         <= bytes_d;
        end
    end

    xgemac_pkt_rx_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk_156m25),
        .rst_n   (reset_156m25_n),
        .wr_en   (wr_en_s),
        .wr_word (wr_word_s),
        .rd_en   (pop_s),
        .rd_word (head_s),
        .count   (fifo_count_s)
    );

    assign out_valid       = (fifo_count_s != '0);
    assign pop_s           = out_valid && out_ready;
    assign out_data        = out_valid ? head_s.data : '0;
    assign out_sop         = out_valid && head_s.sop;
    assign out_eop         = out_valid && head_s.eop;
    assign out_err         = out_valid && head_s.err;
    assign out_mod         = out_valid ? head_s.mod : 3'd0;
    assign frame_len       = frame_len_q;
    assign frame_len_vld   = frame_len_vld_q;
    assign stat_frames_ok  = ok_q;
    assign stat_frames_err = err_q;
    assign stat_bytes      = bytes_q;

endmodule

// File: tb/tb_xgemac_pkt_rx_reader.sv
// Directed self-checking bench for xgemac_pkt_rx_reader with a simple MAC model.
`timescale 1ns/1ps
module tb_xgemac_pkt_rx_reader;
    import xgemac_pkt_rx_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, pkt_rx_avail, pkt_rx_ren, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err;
    logic [2:0]  pkt_rx_mod;
    logic [63:0] pkt_rx_data;
    logic        out_valid, out_ready, out_sop, out_eop, out_err;
    logic [63:0] out_data;
    logic [2:0]  out_mod;
    logic [15:0] frame_len;
    logic        frame_len_vld, stat_clr;
    logic [31:0] stat_frames_ok, stat_frames_err, stat_bytes;

    int          checks = 0;
    int          failures = 0;
    rx_word_t    mac_q[$];
    rx_word_t    exp_q[$];
    int          gap_q[$];
    logic        ren_prev, wait_gap, clr_on_eop;
    int          cyc, eop_cyc, ren_cnt, vld_cnt, v0;
    logic [15:0] last_len;

    always #5 clk = ~clk;

    xgemac_pkt_rx_reader dut (
        .clk_156m25(clk), .reset_156m25_n(rst_n), .enable(enable), .pkt_rx_avail(pkt_rx_avail),
        .pkt_rx_ren(pkt_rx_ren), .pkt_rx_val(pkt_rx_val), .pkt_rx_sop(pkt_rx_sop),
        .pkt_rx_eop(pkt_rx_eop), .pkt_rx_mod(pkt_rx_mod), .pkt_rx_err(pkt_rx_err),
        .pkt_rx_data(pkt_rx_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err),
        .out_mod(out_mod), .frame_len(frame_len), .frame_len_vld(frame_len_vld),
        .stat_clr(stat_clr), .stat_frames_ok(stat_frames_ok),
        .stat_frames_err(stat_frames_err), .stat_bytes(stat_bytes)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mac_idle();
        pkt_rx_val  = 1'b0;
        pkt_rx_sop  = 1'b0;
        pkt_rx_eop  = 1'b0;
        pkt_rx_mod  = 3'd0;
        pkt_rx_err  = 1'b0;
        pkt_rx_data = 64'd0;
    endtask

    // One clock: MAC answers last cycle's ren, then outputs are sampled mid-cycle.
    task automatic tick();
        rx_word_t w;
        rx_word_t e;
        @(negedge clk);
        if (ren_prev && mac_q.size() != 0) begin
            w = mac_q.pop_front();
            pkt_rx_val  = 1'b1;
            pkt_rx_sop  = w.sop;
            pkt_rx_eop  = w.eop;
            pkt_rx_mod  = w.mod;
            pkt_rx_err  = w.err;
            pkt_rx_data = w.data;
        end else begin
            mac_idle();
        end
        pkt_rx_avail = (mac_q.size() != 0);
        if (clr_on_eop) stat_clr = pkt_rx_val && pkt_rx_eop;
        #1;
        cyc++;
        if (pkt_rx_val && pkt_rx_eop) begin
            chk("ren_on_eop", pkt_rx_ren, 1'b0);
            eop_cyc  = cyc;
            wait_gap = 1'b1;
        end else if (wait_gap && pkt_rx_ren) begin
            gap_q.push_back(cyc - eop_cyc);
            wait_gap = 1'b0;
        end
        ren_prev = pkt_rx_ren;
        if (pkt_rx_ren) ren_cnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_word", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("out_word", {out_data, out_sop, out_eop, out_mod, out_err}, e);
            end
        end
        if (frame_len_vld) begin
            vld_cnt++;
            last_len = frame_len;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int id, input int nw, input logic [2:0] last_mod,
                              input logic in_err, input logic exp_err);
        rx_word_t w;
        for (int i = 0; i < nw; i++) begin
            w.data = {id[15:0], 16'hA5C3, i[31:0]};
            w.sop  = (i == 0);
            w.eop  = (i == nw - 1);
            w.mod  = w.eop ? last_mod : 3'd0;
            w.err  = w.eop ? in_err : 1'b0;
            mac_q.push_back(w);
            w.err  = w.eop ? exp_err : 1'b0;
            exp_q.push_back(w);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((mac_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, (mac_q.size() == 0) && (exp_q.size() == 0), 1'b1);
        repeat (3) tick();
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        tick();
    endtask

    task automatic chk_stats(input string tag, input int ok, input int er, input int by);
        chk({tag, "_ok"}, stat_frames_ok, ok);
        chk({tag, "_err"}, stat_frames_err, er);
        chk({tag, "_bytes"}, stat_bytes, by);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; pkt_rx_avail = 1'b0; out_ready = 1'b0; stat_clr = 1'b0;
        mac_idle();
        clr_on_eop = 1'b0; ren_prev = 1'b0; wait_gap = 1'b0;
        cyc = 0; eop_cyc = 0; ren_cnt = 0; vld_cnt = 0; last_len = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_ren", pkt_rx_ren, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_len", frame_len, 16'd0);
        chk("rst_len_vld", frame_len_vld, 1'b0);
        chk_stats("rst", 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // 1: 64-byte frame at full throughput
        enable = 1'b1; out_ready = 1'b1; ren_cnt = 0; v0 = vld_cnt;
        load_frame(1, 8, 3'd0, 1'b0, 1'b0);
        drain("t1", 60);
        chk("t1_ren_cnt", ren_cnt, 8);
        chk("t1_len", last_len, 16'd64);
        chk("t1_vld_pulses", vld_cnt - v0, 1);
        chk_stats("t1", 1, 0, 64);

        // 2: 65-byte frame, downstream stall mid-frame, enable dropped mid-frame
        ren_cnt = 0;
        load_frame(2, 9, 3'd1, 1'b0, 1'b0);
        repeat (3) tick();
        out_ready = 1'b0; enable = 1'b0;
        repeat (5) tick();
        chk("t2_ren_stalled", ren_prev, 1'b0);
        chk("t2_valid_stalled", out_valid, 1'b1);
        out_ready = 1'b1;
        drain("t2", 60);
        enable = 1'b1;
        chk("t2_ren_cnt", ren_cnt, 9);
        chk("t2_len", last_len, 16'd65);
        chk_stats("t2", 2, 0, 129);

        // 3: 60-byte frame with MAC error on eop
        clear_stats();
        chk_stats("clr", 0, 0, 0);
        load_frame(3, 8, 3'd4, 1'b1, 1'b1);
        drain("t3", 60);
        chk("t3_len", last_len, 16'd60);
        chk_stats("t3", 0, 1, 60);

        // 4: exactly max size is fine, two bytes over is flagged
        clear_stats();
        load_frame(4, 190, 3'd6, 1'b0, 1'b0);
        drain("t4a", 400);
        chk("t4a_len", last_len, 16'd1518);
        chk_stats("t4a", 1, 0, 1518);
        clear_stats();
        load_frame(5, 190, 3'd0, 1'b0, 1'b1);
        drain("t4b", 400);
        chk("t4b_len", last_len, 16'd1520);
        chk_stats("t4b", 0, 1, 1520);

        // 5: two frames back to back with avail held
        clear_stats();
        gap_q.delete(); wait_gap = 1'b0;
        load_frame(6, 2, 3'd0, 1'b0, 1'b0);
        load_frame(7, 3, 3'd5, 1'b0, 1'b0);
        drain("t5", 60);
        chk("t5_gap_count", gap_q.size(), 1);
        chk("t5_gap", (gap_q.size() != 0) ? gap_q[0] : -1, 2);
        chk("t5_len", last_len, 16'd21);
        chk_stats("t5", 2, 0, 37);

        // 6: asynchronous reset mid-frame, then a clean frame
        out_ready = 1'b0;
        load_frame(8, 8, 3'd0, 1'b0, 1'b0);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ren", pkt_rx_ren, 1'b0);
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_out_data", out_data, 64'd0);
        chk("t6_out_sop", out_sop, 1'b0);
        chk("t6_len", frame_len, 16'd0);
        chk_stats("t6_rst", 0, 0, 0);
        mac_q.delete(); exp_q.delete();
        ren_prev = 1'b0; wait_gap = 1'b0;
        mac_idle(); pkt_rx_avail = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        load_frame(9, 4, 3'd0, 1'b0, 1'b0);
        drain("t6b", 60);
        chk("t6b_len", last_len, 16'd32);
        chk_stats("t6b", 1, 0, 32);

        // Clear coinciding with a statistics update
        clr_on_eop = 1'b1;
        load_frame(10, 3, 3'd2, 1'b0, 1'b0);
        drain("t6c", 60);
        clr_on_eop = 1'b0; stat_clr = 1'b0;
        chk("t6c_len", last_len, 16'd18);
        chk_stats("t6c", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
